fifo_lvl: RTL
=============

// Module: fifo_lvl
// PURPOSE
//  Parametric synchronous FIFO, successor to the basic fifo. Adds a fill-level count,
//  programmable almost-full/almost-empty flags, a selectable read mode (first-word-
//  fall-through or registered), and sticky overflow/underflow error flags.
//  Used as the general buffering primitive between same-clock producer/consumer stages.
// PARAMETERS
//  DATA_W     8  data width in bits, >=1
//  ENTRIES_N  8  depth; power of 2, >=2 (elaboration error otherwise)
//  AFULL_TH   6  afull_o asserted when level >= AFULL_TH; 1..ENTRIES_N
//  AEMPTY_TH  2  aempty_o asserted when level <= AEMPTY_TH; 0..ENTRIES_N-1
//  FWFT       1  1: first-word-fall-through read; 0: registered read, 1-cycle latency
// PORTS
//  clk        in   1          clock, all state on rising edge
//  nreset     in   1          asynchronous active-low reset
//  wr_i       in   1          write request
//  wr_data_i  in   DATA_W     write data, sampled when write accepted
//  rd_i       in   1          read request / pop
//  rd_data_o  out  DATA_W     read data
//  rd_valid_o out  1          rd_data_o valid (meaning depends on FWFT)
//  full_o     out  1          level == ENTRIES_N
//  empty_o    out  1          level == 0
//  afull_o    out  1          almost full
//  aempty_o   out  1          almost empty
//  level_o    out  CNT_W      entries stored; CNT_W = $clog2(ENTRIES_N)+1
//  ovf_o      out  1          sticky overflow error
//  udf_o      out  1          sticky underflow error
//  clr_err_i  in   1          clears ovf_o/udf_o
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers, level 0; empty_o=1, aempty_o=1,
//    full_o=afull_o=0, ovf_o=udf_o=0, rd_valid_o=0, rd_data_o=0.
//  - Ptrs are $clog2(ENTRIES_N)+1 bits; MSB is wrap bit; index = low bits, wraps mod depth.
//  - rd_acc = rd_i & ~empty_o. wr_acc = wr_i & (~full_o | rd_acc): write on full is
//    accepted iff a read is accepted the same cycle (level stays ENTRIES_N).
//  - Read on empty with simultaneous write: read rejected, write accepted, udf_o set.
//  - level_o next = level + wr_acc - rd_acc; never exceeds ENTRIES_N or goes below 0.
//  - All flags are decoded from registered state: they reflect an accepted op the
//    cycle after it (e.g. first write -> empty_o falls next cycle).
//  - FWFT=1: rd_data_o = mem[rd_ptr] combinationally, rd_valid_o = ~empty_o;
//    rd_i pops the shown word; next word visible the following cycle.
//  - FWFT=0: on rd_acc, rd_data_o <= mem[rd_ptr] and rd_valid_o <= 1 next cycle;
//    else rd_valid_o <= 0, rd_data_o holds last value.
//  - ovf_o set on wr_i & ~wr_acc; udf_o set on rd_i & ~rd_acc. Rejected ops change no
//    other state. Sticky until clr_err_i; set and clear same cycle -> set wins.
//  - Storage is not reset; contents beyond level are don't-care.
//  - nreset asserted mid-operation: FIFO empties immediately, stored data discarded.
// TESTING
//  1 Reset, 8 writes 0x10..0x17, no reads -> full_o=1, afull_o=1 from level 6, level_o=8.
//  2 Write while full, no read -> data dropped, ovf_o=1, level_o stays 8; clr_err_i -> ovf_o=0.
//  3 Full + wr_i&rd_i same cycle (FWFT=1) -> 0x10 popped, new word stored, level_o=8, ovf_o=0.
//  4 FWFT=0: write 0xA5, read -> rd_valid_o=1 with rd_data_o=0xA5 one cycle after rd_i.
//  5 Empty, rd_i&wr_i(0x3C) -> udf_o=1, level_o=1; next cycle FWFT=1 shows rd_data_o=0x3C.
//  6 20 write/read cycles through depth 8 -> pointer wrap, data in order, no error flags.

Source files
------------

// File: rtl/fifo_lvl.sv
// Synchronous FIFO with fill level, almost-full/empty thresholds, FWFT or registered read, sticky errors.
// Latency: FWFT=1 head word visible the cycle after its write; FWFT=0 read data one cycle after rd_i. Write-on-full accepted only alongside a read.
module fifo_lvl #(
    parameter int DATA_W    = 8,
    parameter int ENTRIES_N = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = 1'b1,
    localparam int AW       = $clog2(ENTRIES_N),
    localparam int CNT_W    = AW + 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              afull_o,
    output logic              aempty_o,
    output logic [CNT_W-1:0]  level_o,
    output logic              ovf_o,
    output logic              udf_o,
    input  logic              clr_err_i
);

    generate
        if (ENTRIES_N < 2 || (ENTRIES_N & (ENTRIES_N - 1)) != 0) begin : g_bad_depth
            $error("fifo_lvl: ENTRIES_N must be a power of 2 and >= 2");
        end
        if (AFULL_TH < 1 || AFULL_TH > ENTRIES_N) begin : g_bad_afull
            $error("fifo_lvl: AFULL_TH out of range");
        end
        if (AEMPTY_TH < 0 || AEMPTY_TH > ENTRIES_N - 1) begin : g_bad_aempty
            $error("fifo_lvl: AEMPTY_TH out of range");
        end
        if (DATA_W < 1) begin : g_bad_width
            $error("fifo_lvl: DATA_W must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] AFULL_LV = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMP_LV  = CNT_W'(AEMPTY_TH);
    localparam logic [CNT_W-1:0] WRAP_PAT = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] mem [ENTRIES_N];

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q,  level_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    logic             full, empty;
    logic             rd_acc, wr_acc;
    logic [AW-1:0]    rd_idx, wr_idx;

    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];

    // Pointers differ only in the wrap bit when full; identical when empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == WRAP_PAT);

    assign rd_acc = rd_i & ~empty;
    assign wr_acc = wr_i & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        level_d = level_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
        // Set takes priority over a same-cycle clear so no error is lost.
        ovf_d = (wr_i & ~wr_acc) | (ovf_q & ~clr_err_i);
        udf_d = (rd_i & ~rd_acc) | (udf_q & ~clr_err_i);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_idx] <= wr_data_i;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Storage is never reset, so the head word is masked while empty.
            assign rd_data_o  = empty ? '0 : mem[rd_idx];
            assign rd_valid_o = ~empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_idx];
                    end
                end
            end

            assign rd_data_o  = rd_data_q;
            assign rd_valid_o = rd_valid_q;
        end
    endgenerate

    assign full_o   = full;
    assign empty_o  = empty;
    assign afull_o  = (level_q >= AFULL_LV);
    assign aempty_o = (level_q <= AEMP_LV);
    assign level_o  = level_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

endmodule
